// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Opcodes, ALU op codes, mux selects, FSM state encodings.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ANDI_EX  = 4'd11,
        S_IMM_WB   = 4'd12,
        S_JUMP     = 4'd13,
        S_TRAP     = 4'd15
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic state_e dispatch(logic [5:0] op);
        state_e s;
        unique case (op)
            OP_LW, OP_SW:     s = S_MEMADR;
            OP_RTYPE:         s = S_RTYPE_EX;
            OP_BEQ, OP_BNE:   s = S_BRANCH;
            OP_ADDI:          s = S_ADDI_EX;
            OP_ANDI:          s = S_ANDI_EX;
            OP_J:             s = S_JUMP;
            default:          s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the main FSM and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(parameter int OPW = 6);

    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           pc_write;
    logic           pc_write_cond;
    logic           branch_ne;
    logic           i_or_d;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           mem_to_reg;
    logic           reg_dst;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic           ext_zero;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic           illegal_op;
    logic [3:0]     state_dbg;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d,
        output mem_read, mem_write, ir_write, mem_to_reg,
        output reg_dst, reg_write, alu_src_a, alu_src_b,
        output ext_zero, alu_op, pc_source, illegal_op,
        output state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d,
        input  mem_read, mem_write, ir_write, mem_to_reg,
        input  reg_dst, reg_write, alu_src_a, alu_src_b,
        input  ext_zero, alu_op, pc_source, illegal_op,
        input  state_dbg
    );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// State-to-control decoder for the multicycle FSM.
// Pure combinational; only FETCH looks at mem_ready.
module multicycle_ctrl_decode
    import mips_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    input  logic   is_bne,
    output ctrl_t  ctrl
);

    // Moore decode; anything not set for a state stays 0
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_IDLE: ;
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = is_bne;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ANDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_AND;
                ctrl.ext_zero  = 1'b1;
            end
            S_IMM_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// Holds the state register and next-state logic.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_e         state_q;
    state_e         state_d;
    logic [OPW-1:0] op;
    ctrl_t          ctrl;

    assign op = bus.opcode;

    // next state; memory states hold until mem_ready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = dispatch(op);
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (bus.mem_ready) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_IMM_WB;
            S_ANDI_EX:  state_d = S_IMM_WB;
            S_IMM_WB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    // state register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    multicycle_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .is_bne    (op == OP_BNE),
        .ctrl      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.branch_ne     = ctrl.branch_ne;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.ext_zero      = ctrl.ext_zero;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Cycle-count table, instruction-level reference model, reset corners.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.OPW(6)) bus ();

    multicycle_ctrl #(.OPW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_ANDI = 6'b001100;
    localparam logic [5:0] T_J    = 6'b000010;

    typedef enum int {
        P_FETCH, P_DEC, P_ADDR, P_RD, P_LWB, P_WR, P_REX,
        P_RWB, P_BR, P_ADDI, P_ANDI, P_IWB, P_J, P_TRAP
    } ph_e;

    ph_e plan[$];

    typedef struct {
        logic [5:0] op;
        int         wa;
        int         wn;
        int         cyc;
        int         rw;
        int         ir;
    } vec_t;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] dvec();
        return {bus.pc_write, bus.pc_write_cond, bus.branch_ne,
                bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.ext_zero, bus.alu_op, bus.pc_source,
                bus.illegal_op};
    endfunction

    // expected control word for one step of an instruction
    function automatic logic [18:0] pvec(ph_e p, logic rdy, logic [5:0] op);
        logic pw, pwc, bne, iord, mr, mw, irw, m2r, rdst, rw, asa, ez, ill;
        logic [1:0] asb, aop, psrc;
        pw = 0; pwc = 0; bne = 0; iord = 0; mr = 0; mw = 0; irw = 0;
        m2r = 0; rdst = 0; rw = 0; asa = 0; ez = 0; ill = 0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (p)
            P_FETCH: begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            P_DEC:   asb = 2'b11;
            P_ADDR:  begin asa = 1; asb = 2'b10; end
            P_RD:    begin mr = 1; iord = 1; end
            P_LWB:   begin rw = 1; m2r = 1; end
            P_WR:    begin mw = 1; iord = 1; end
            P_REX:   begin asa = 1; aop = 2'b10; end
            P_RWB:   begin rw = 1; rdst = 1; end
            P_BR: begin
                asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01;
                bne = (op == T_BNE);
            end
            P_ADDI:  begin asa = 1; asb = 2'b10; end
            P_ANDI:  begin asa = 1; asb = 2'b10; aop = 2'b11; ez = 1; end
            P_IWB:   rw = 1;
            P_J:     begin pw = 1; psrc = 2'b10; end
            P_TRAP:  ill = 1;
            default: ;
        endcase
        return {pw, pwc, bne, iord, mr, mw, irw, m2r, rdst, rw,
                asa, asb, ez, aop, psrc, ill};
    endfunction

    // steps an instruction walks through after fetch
    function automatic void mkplan(logic [5:0] op);
        case (op)
            T_LW:         plan = '{P_DEC, P_ADDR, P_RD, P_LWB};
            T_SW:         plan = '{P_DEC, P_ADDR, P_WR};
            T_R:          plan = '{P_DEC, P_REX, P_RWB};
            T_BEQ, T_BNE: plan = '{P_DEC, P_BR};
            T_ADDI:       plan = '{P_DEC, P_ADDI, P_IWB};
            T_ANDI:       plan = '{P_DEC, P_ANDI, P_IWB};
            T_J:          plan = '{P_DEC, P_J};
            default:      plan = '{P_DEC, P_TRAP};
        endcase
    endfunction

    task automatic step(logic rdy, logic [5:0] drv, logic [5:0] op, ph_e p);
        bus.mem_ready = rdy;
        bus.opcode = drv;
        @(negedge clk);
        chk(p.name(), 32'(dvec()), 32'(pvec(p, rdy, op)));
        if (p == P_FETCH) chk("dbg_fetch", 32'(bus.state_dbg), 32'd1);
        if (p == P_TRAP) chk("dbg_trap", 32'(bus.state_dbg), 32'd15);
        @(posedge clk);
        #1;
    endtask

    task automatic run_model(logic [5:0] op, int fw, int mwt);
        repeat (fw) step(1'b0, 6'($urandom), op, P_FETCH);
        step(1'b1, 6'($urandom), op, P_FETCH);
        mkplan(op);
        foreach (plan[i]) begin
            if (plan[i] == P_RD || plan[i] == P_WR) begin
                repeat (mwt) step(1'b0, op, op, plan[i]);
                step(1'b1, op, op, plan[i]);
            end else begin
                step(1'($urandom), op, op, plan[i]);
            end
        end
    endtask

    task automatic run_count(input logic [5:0] op, input int wa,
                             input int wn, output int cyc,
                             output int rw, output int ir);
        bit seen;
        cyc = 0; rw = 0; ir = 0; seen = 0;
        do begin
            bus.mem_ready = (cyc >= wa && cyc < wa + wn) ? 1'b0 : 1'b1;
            bus.opcode = op;
            @(negedge clk);
            rw += int'(bus.reg_write);
            ir += int'(bus.ir_write);
            @(posedge clk);
            #1;
            cyc++;
            if (bus.state_dbg != 4'd1) seen = 1;
        end while (!(seen && bus.state_dbg == 4'd1) && cyc < 40);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[10];
        logic [5:0] ops[8];
        int c, r, i_cnt;

        tbl[0] = '{T_R,    0, 0, 4, 1, 1};
        tbl[1] = '{T_LW,   3, 2, 7, 1, 1};
        tbl[2] = '{T_LW,   0, 2, 7, 1, 1};
        tbl[3] = '{T_SW,   3, 1, 5, 0, 1};
        tbl[4] = '{T_BEQ,  0, 0, 3, 0, 1};
        tbl[5] = '{T_BNE,  0, 0, 3, 0, 1};
        tbl[6] = '{T_J,    0, 0, 3, 0, 1};
        tbl[7] = '{T_ADDI, 1, 2, 4, 1, 1};
        tbl[8] = '{T_ANDI, 0, 0, 4, 1, 1};
        tbl[9] = '{T_SW,   0, 0, 4, 0, 1};
        ops = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_ANDI, T_J};

        bus.mem_ready = 1'b1;
        bus.opcode = T_R;
        @(negedge clk);
        chk("rst_vec", 32'(dvec()), 32'd0);
        chk("rst_dbg", 32'(bus.state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_vec", 32'(dvec()), 32'd0);
        chk("idle_dbg", 32'(bus.state_dbg), 32'd0);
        @(posedge clk);
        #1;
        chk("first_fetch", 32'(bus.state_dbg), 32'd1);

        foreach (tbl[k]) begin
            run_count(tbl[k].op, tbl[k].wa, tbl[k].wn, c, r, i_cnt);
            chk($sformatf("cyc%0d", k), 32'(c), 32'(tbl[k].cyc));
            chk($sformatf("rw%0d", k), 32'(r), 32'(tbl[k].rw));
            chk($sformatf("ir%0d", k), 32'(i_cnt), 32'(tbl[k].ir));
        end

        for (int n = 0; n < 150; n++) begin
            run_model(ops[$urandom_range(0, 7)],
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        run_model(6'b111111, 0, 0);
        for (int n = 0; n < 20; n++) begin
            step(1'($urandom), 6'($urandom), 6'b111111, P_TRAP);
        end
        rst_n = 1'b0;
        #1;
        chk("trap_rst_ill", 32'(bus.illegal_op), 32'd0);
        chk("trap_rst_dbg", 32'(bus.state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(1'b1, T_SW, T_SW, P_FETCH);
        step(1'b1, T_SW, T_SW, P_DEC);
        step(1'b1, T_SW, T_SW, P_ADDR);
        step(1'b0, T_SW, T_SW, P_WR);
        chk("memwr_held", 32'(bus.mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("memwr_rst_mw", 32'(bus.mem_write), 32'd0);
        chk("memwr_rst_dbg", 32'(bus.state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_model(T_SW, 0, 0);
        run_model(T_J, 0, 0);
        run_count(T_SW, 0, 0, c, r, i_cnt);
        chk("b2b_sw", 32'(c), 32'd4);
        run_count(T_J, 0, 0, c, r, i_cnt);
        chk("b2b_j", 32'(c), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
